dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of cycles mem_en_o is held per access (legal 1..15).
REQ-002 SHALL have parameter AW, default 32, address width of all address ports.
REQ-003 SHALL have ports, in order:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  MEM-stage access request
- cpu_we_i  in  1  CPU write (1) / read (0)
- cpu_addr_i  in  AW  CPU byte address
- cpu_wdata_i  in  32  CPU store data
- cpu_rdata_o  out  32  CPU load data
- cpu_stall_o  out  1  pipeline freeze
- dma_req_i  in  1  loader/DMA request
- dma_we_i  in  1  DMA write/read
- dma_addr_i  in  AW  DMA byte address
- dma_wdata_i  in  32  DMA store data
- dma_rdata_o  out  32  DMA read data
- dma_ack_o  out  1  DMA completion pulse
- mem_en_o  out  1  data-memory enable
- mem_we_o  out  1  data-memory write
- mem_addr_o  out  AW  data-memory address
- mem_wdata_o  out  32  data-memory write data
- mem_rdata_i  in  32  data-memory read data, valid in last enabled cycle

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESP; transitions: IDLE->ACCESS when any request is sampled high; ACCESS->RESP when the latency counter reaches LATENCY-1; RESP->IDLE unconditionally.
REQ-005 SHALL, on IDLE->ACCESS, latch grant owner, we, addr and wdata of the winner; latched values SHALL drive mem_we_o/mem_addr_o/mem_wdata_o, ignoring later input changes.
REQ-006 SHALL assert mem_en_o for exactly LATENCY consecutive cycles (all ACCESS cycles) per transaction, and never in IDLE or RESP.
REQ-007 SHALL drive mem_we_o, mem_addr_o, mem_wdata_o to 0 whenever mem_en_o is 0.
REQ-008 SHALL capture mem_rdata_i on the edge leaving the last ACCESS cycle into the owner's rdata register; the other requester's rdata register SHALL hold its value; writes SHALL leave both unchanged.
REQ-009 SHALL drive cpu_stall_o = cpu_req_i AND NOT (state==RESP AND owner==CPU), combinationally; a CPU access therefore stalls exactly LATENCY+1 cycles from request assertion in IDLE.
REQ-010 SHALL pulse dma_ack_o high for exactly the one RESP cycle of a DMA-owned transaction; DMA SHALL hold its request fields stable until it sees the ack.
REQ-011 SHALL, when only one requester is high in IDLE, grant that requester.
REQ-012 SHALL, when both are high in IDLE, resolve per REQ-017/REQ-018.
REQ-013 SHALL complete a started transaction (including the write) if its request drops mid-ACCESS; data SHALL still be captured, dma_ack_o SHALL still pulse, and the transaction SHALL not be retried.
REQ-014 SHALL keep the latency counter 4 bits wide, cleared on entry to ACCESS, never wrapping.

Reset
REQ-015 SHALL, while rst_i is high, asynchronously force: state IDLE, counter 0, owner CPU, cpu_rdata_o 0, dma_rdata_o 0, dma_ack_o 0, mem_en_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0; cpu_stall_o follows REQ-009 (equal to cpu_req_i).
REQ-016 SHALL abandon any in-flight transaction on reset with no retry; the first arbitration SHALL occur on the first rising edge after rst_i falls.

Configuration
REQ-017 SHALL, with DMEM_ARB_RR_EN defined, resolve simultaneous requests round-robin: the winner is the requester that did not own the most recent completed transaction (after reset the CPU counts as last owner, so DMA wins first).
REQ-018 SHALL, without DMEM_ARB_RR_EN, give the CPU fixed priority on every simultaneous request; DMA is served only when cpu_req_i is low in IDLE.

Verification
REQ-019 CPU read, LATENCY=2, mem_rdata_i=0x0000_0005 at addr 0x08 -> cpu_stall_o high 3 cycles, mem_en_o high 2 cycles, cpu_rdata_o=5 in RESP cycle.
REQ-020 DMA write addr 0x1C data 0xDEAD_BEEF -> mem_we_o=1 for 2 cycles, dma_ack_o one-cycle pulse in the 3rd cycle, cpu_rdata_o unchanged.
REQ-021 CPU and DMA both held high for 4 transactions, RR_EN undefined -> grant order CPU,CPU,CPU,CPU, dma_ack_o never pulses; with DMEM_ARB_RR_EN defined -> DMA,CPU,DMA,CPU.
REQ-022 rst_i raised in 2nd ACCESS cycle of a CPU write -> mem_en_o drops the same cycle, state IDLE, all outputs 0; after release a pending DMA read is served normally.
REQ-023 DMA request dropped after 1st ACCESS cycle, LATENCY=3 -> mem_en_o still 3 cycles, dma_ack_o pulses once, no second transaction.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage, loader/DMA) arbiter in front of a single-port data memory.
// Simultaneous requests: CPU fixed priority by default; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [31:0]   dma_wdata_i,
    output logic [31:0]   dma_rdata_o,
    output logic          dma_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;
    logic          grant_dma;

`ifdef DMEM_ARB_RR_EN
    // Remember who finished last; the other requester wins the next tie.
    owner_e last_owner_q, last_owner_d;
    logic   last_access;

    assign last_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);
    assign grant_dma   = dma_req_i && (!cpu_req_i || (last_owner_q == OWN_CPU));

    always_comb begin
        last_owner_d = last_owner_q;
        if (last_access) begin
            last_owner_d = owner_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_owner_q <= OWN_CPU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign grant_dma = dma_req_i && !cpu_req_i;
`endif

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    if (grant_dma) begin
                        owner_d = OWN_DMA;
                        we_d    = dma_we_i;
                        addr_d  = dma_addr_i;
                        wdata_d = dma_wdata_i;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    // Memory read data is only guaranteed in the last enabled cycle.
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only; the read-data registers are
    // ordinary flops and are reset along with the control state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Memory bus is quiet (all zero) outside ACCESS.
    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = mem_en_o ? addr_q : '0;
    assign mem_wdata_o = mem_en_o ? wdata_q : '0;

    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign dma_ack_o   = (state_q == RESP) && (owner_q == OWN_DMA);
    assign cpu_stall_o = cpu_req_i && !((state_q == RESP) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a queue-based scoreboard watches the memory bus of a
// LATENCY=2 instance; a second LATENCY=3 instance covers a DMA request dropped mid-access.
module tb_dmem_arbiter;
    localparam int LAT  = 2;
    localparam int LAT3 = 3;
    localparam int AW   = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [31:0]   cpu_wdata_i = '0;
    logic [31:0]   cpu_rdata_o;
    logic          cpu_stall_o;
    logic          dma_req_i = 1'b0, dma_we_i = 1'b0;
    logic [AW-1:0] dma_addr_i = '0;
    logic [31:0]   dma_wdata_i = '0;
    logic [31:0]   dma_rdata_o;
    logic          dma_ack_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    logic          d3_dma_req = 1'b0;
    logic [AW-1:0] d3_dma_addr = '0;
    logic [31:0]   d3_cpu_rdata, d3_dma_rdata, d3_mem_wdata, d3_mem_rdata;
    logic          d3_cpu_stall, d3_dma_ack, d3_mem_en, d3_mem_we;
    logic [AW-1:0] d3_mem_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h8) return 32'h0000_0005;
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign mem_rdata_i  = mem_val(mem_addr_o);
    assign d3_mem_rdata = mem_val(d3_mem_addr);

    dmem_arbiter #(.LATENCY(LAT), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    dmem_arbiter #(.LATENCY(LAT3), .AW(AW)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(1'b0), .cpu_we_i(1'b0), .cpu_addr_i('0),
        .cpu_wdata_i(32'h0), .cpu_rdata_o(d3_cpu_rdata), .cpu_stall_o(d3_cpu_stall),
        .dma_req_i(d3_dma_req), .dma_we_i(1'b0), .dma_addr_i(d3_dma_addr),
        .dma_wdata_i(32'h0), .dma_rdata_o(d3_dma_rdata), .dma_ack_o(d3_dma_ack),
        .mem_en_o(d3_mem_en), .mem_we_o(d3_mem_we), .mem_addr_o(d3_mem_addr),
        .mem_wdata_o(d3_mem_wdata), .mem_rdata_i(d3_mem_rdata)
    );

    // Scoreboard monitor: pops one expectation per enable burst and tracks expected read data.
    exp_t        mon_cur = '{dma: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    logic        mon_prev_en = 1'b0;
    int          mon_en_cnt = 0;
    logic [31:0] mon_cpu = '0, mon_dma = '0;
    logic        mon_ack;

    always @(negedge clk_i) begin
        if (rst_i) begin
            mon_prev_en = 1'b0;
            mon_en_cnt  = 0;
            mon_cpu     = '0;
            mon_dma     = '0;
        end else begin
            if (mem_en_o) begin
                if (!mon_prev_en) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_txn: got access at addr %h, expected none", mem_addr_o);
                        mon_cur = '{dma: 1'b0, we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o};
                    end else begin
                        mon_cur = exp_q.pop_front();
                    end
                    mon_en_cnt = 0;
                end
                mon_en_cnt++;
                total++;
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {mon_cur.we, mon_cur.addr, mon_cur.wdata}) begin
                    bad++;
                    $display("FAIL sb_mem_bus: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                             mem_we_o, mem_addr_o, mem_wdata_o, mon_cur.we, mon_cur.addr, mon_cur.wdata);
                end
            end else begin
                total++;
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
                    bad++;
                    $display("FAIL sb_bus_idle_zero: got we=%b addr=%h wdata=%h expected all 0",
                             mem_we_o, mem_addr_o, mem_wdata_o);
                end
                if (mon_prev_en) begin
                    total++;
                    if (mon_en_cnt !== LAT) begin
                        bad++;
                        $display("FAIL sb_en_length: got %0d cycles expected %0d", mon_en_cnt, LAT);
                    end
                    if (!mon_cur.we) begin
                        if (mon_cur.dma) mon_dma = mem_val(mon_cur.addr);
                        else             mon_cpu = mem_val(mon_cur.addr);
                    end
                    if (!mon_cur.dma) begin
                        total++;
                        if (cpu_stall_o !== 1'b0) begin
                            bad++;
                            $display("FAIL sb_cpu_release: got stall=%b expected 0", cpu_stall_o);
                        end
                    end
                end
            end
            mon_ack = !mem_en_o && mon_prev_en && mon_cur.dma;
            total++;
            if (dma_ack_o !== mon_ack) begin
                bad++;
                $display("FAIL sb_dma_ack: got %b expected %b", dma_ack_o, mon_ack);
            end
            total++;
            if ({cpu_rdata_o, dma_rdata_o} !== {mon_cpu, mon_dma}) begin
                bad++;
                $display("FAIL sb_rdata: got cpu=%h dma=%h expected cpu=%h dma=%h",
                         cpu_rdata_o, dma_rdata_o, mon_cpu, mon_dma);
            end
            mon_prev_en = mem_en_o;
        end
    end

    task automatic test_reset();
        rst_i     = 1'b1;
        cpu_req_i = 1'b1;
        #1;
        total++;
        if (cpu_stall_o !== 1'b1) begin
            bad++; $display("FAIL reset_stall_follows_req: got %b expected 1", cpu_stall_o);
        end
        cpu_req_i = 1'b0;
        #1;
        total++;
        if ({cpu_stall_o, mem_en_o, mem_we_o, dma_ack_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 0000", {cpu_stall_o, mem_en_o, mem_we_o, dma_ack_o});
        end
        total++;
        if ({mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o} !== '0) begin
            bad++; $display("FAIL reset_data: got addr=%h wdata=%h crd=%h drd=%h expected 0",
                            mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (mem_en_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle_no_req: got en=%b expected 0", mem_en_o);
        end
    endtask

    task automatic test_cpu_read();
        int n;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h08;
        cpu_wdata_i = 32'h1111_2222;
        cpu_req_i   = 1'b1;
        exp_q.push_back('{dma: 1'b0, we: 1'b0, addr: 32'h08, wdata: 32'h1111_2222});
        #1;
        n = cpu_stall_o ? 1 : 0;
        for (int i = 0; i < 20 && cpu_stall_o; i++) begin
            @(negedge clk_i);
            if (cpu_stall_o) n++;
        end
        cpu_req_i = 1'b0;
        total++;
        if (n !== LAT + 1) begin
            bad++; $display("FAIL cpu_read_stall_cycles: got %0d expected %0d", n, LAT + 1);
        end
        total++;
        if (cpu_rdata_o !== 32'h5) begin
            bad++; $display("FAIL cpu_read_data: got %h expected 00000005", cpu_rdata_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_dma_write();
        int          k;
        logic [31:0] cpu_before;
        cpu_before  = cpu_rdata_o;
        dma_we_i    = 1'b1;
        dma_addr_i  = 32'h1C;
        dma_wdata_i = 32'hDEAD_BEEF;
        dma_req_i   = 1'b1;
        exp_q.push_back('{dma: 1'b1, we: 1'b1, addr: 32'h1C, wdata: 32'hDEAD_BEEF});
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            k++;
            if (dma_ack_o) break;
        end
        dma_req_i = 1'b0;
        total++;
        if (k !== LAT + 1) begin
            bad++; $display("FAIL dma_write_ack_cycle: got %0d expected %0d", k, LAT + 1);
        end
        @(negedge clk_i);
        total++;
        if (dma_ack_o !== 1'b0) begin
            bad++; $display("FAIL dma_write_ack_pulse: got %b expected 0", dma_ack_o);
        end
        total++;
        if (cpu_rdata_o !== cpu_before) begin
            bad++; $display("FAIL dma_write_cpu_rdata_held: got %h expected %h", cpu_rdata_o, cpu_before);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            logic          d, w, prev, done;
            logic [AW-1:0] a;
            logic [31:0]   wd;
            d  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(1, 63) * 4);
            wd = $urandom;
            if (d) begin
                dma_we_i = w; dma_addr_i = a; dma_wdata_i = wd; dma_req_i = 1'b1;
            end else begin
                cpu_we_i = w; cpu_addr_i = a; cpu_wdata_i = wd; cpu_req_i = 1'b1;
            end
            exp_q.push_back('{dma: d, we: w, addr: a, wdata: wd});
            prev = 1'b0;
            done = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                if (prev && !mem_en_o) begin
                    done = 1'b1;
                    break;
                end
                prev = mem_en_o;
            end
            cpu_req_i = 1'b0;
            dma_req_i = 1'b0;
            total++;
            if (done !== 1'b1) begin
                bad++; $display("FAIL b2b_complete[%0d]: got no completion expected completion", t);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_both();
        bit            exp_dma[4];
        logic [AW-1:0] got[4];
        logic [AW-1:0] want;
        int            n_rise, n_done, acks, exp_acks;
        logic          prev;
`ifdef DMEM_ARB_RR_EN
        exp_dma[0] = 1'b1; exp_dma[1] = 1'b0; exp_dma[2] = 1'b1; exp_dma[3] = 1'b0;
        exp_acks = 2;
`else
        exp_dma[0] = 1'b0; exp_dma[1] = 1'b0; exp_dma[2] = 1'b0; exp_dma[3] = 1'b0;
        exp_acks = 0;
`endif
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_wdata_i = 32'hC0C0; cpu_req_i = 1'b1;
        dma_we_i = 1'b0; dma_addr_i = 32'h80; dma_wdata_i = 32'hD0D0; dma_req_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            got[j] = '0;
            if (exp_dma[j]) exp_q.push_back('{dma: 1'b1, we: 1'b0, addr: 32'h80, wdata: 32'hD0D0});
            else            exp_q.push_back('{dma: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'hC0C0});
        end
        n_rise = 0; n_done = 0; acks = 0; prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (mem_en_o && !prev) begin
                if (n_rise < 4) got[n_rise] = mem_addr_o;
                n_rise++;
            end
            if (dma_ack_o) acks++;
            if (prev && !mem_en_o) begin
                n_done++;
                if (n_done == 4) break;
            end
            prev = mem_en_o;
        end
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;
        total++;
        if (n_done !== 4) begin
            bad++; $display("FAIL both_txn_count: got %0d expected 4", n_done);
        end
        for (int j = 0; j < 4; j++) begin
            want = exp_dma[j] ? 32'h80 : 32'h40;
            total++;
            if (got[j] !== want) begin
                bad++; $display("FAIL both_grant_order[%0d]: got addr %h expected %h", j, got[j], want);
            end
        end
        total++;
        if (acks !== exp_acks) begin
            bad++; $display("FAIL both_ack_count: got %0d expected %0d", acks, exp_acks);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_midaccess();
        int k;
        cpu_we_i = 1'b1; cpu_addr_i = 32'h20; cpu_wdata_i = 32'h1234_5678; cpu_req_i = 1'b1;
        exp_q.push_back('{dma: 1'b0, we: 1'b1, addr: 32'h20, wdata: 32'h1234_5678});
        @(negedge clk_i);
        dma_we_i = 1'b0; dma_addr_i = 32'h30; dma_wdata_i = 32'h0; dma_req_i = 1'b1;
        @(posedge clk_i);
        #2;
        total++;
        if (mem_en_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_in_access: got en=%b expected 1", mem_en_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if ({mem_en_o, mem_we_o, dma_ack_o, cpu_stall_o} !== 4'b0001) begin
            bad++; $display("FAIL rst_mid_ctrl: got %b expected 0001", {mem_en_o, mem_we_o, dma_ack_o, cpu_stall_o});
        end
        total++;
        if ({mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o} !== '0) begin
            bad++; $display("FAIL rst_mid_data: got addr=%h wdata=%h crd=%h drd=%h expected 0",
                            mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o);
        end
        cpu_req_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        exp_q.push_back('{dma: 1'b1, we: 1'b0, addr: 32'h30, wdata: 32'h0});
        @(negedge clk_i);
        rst_i = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            k++;
            if (dma_ack_o) break;
        end
        dma_req_i = 1'b0;
        total++;
        if (k !== LAT + 1) begin
            bad++; $display("FAIL rst_mid_dma_ack_cycle: got %0d expected %0d", k, LAT + 1);
        end
        total++;
        if (dma_rdata_o !== mem_val(32'h30)) begin
            bad++; $display("FAIL rst_mid_dma_rdata: got %h expected %h", dma_rdata_o, mem_val(32'h30));
        end
        @(negedge clk_i);
    endtask

    task automatic test_dma_drop();
        int en_cnt, acks;
        d3_dma_addr = 32'h44;
        d3_dma_req  = 1'b1;
        @(negedge clk_i);
        en_cnt = d3_mem_en ? 1 : 0;
        acks   = d3_dma_ack ? 1 : 0;
        d3_dma_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (d3_mem_en)  en_cnt++;
            if (d3_dma_ack) acks++;
        end
        total++;
        if (en_cnt !== LAT3) begin
            bad++; $display("FAIL drop_en_cycles: got %0d expected %0d", en_cnt, LAT3);
        end
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL drop_ack_count: got %0d expected 1", acks);
        end
        total++;
        if (d3_dma_rdata !== mem_val(32'h44)) begin
            bad++; $display("FAIL drop_dma_rdata: got %h expected %h", d3_dma_rdata, mem_val(32'h44));
        end
        total++;
        if ({d3_cpu_stall, d3_mem_we, d3_mem_addr, d3_mem_wdata, d3_cpu_rdata} !== '0) begin
            bad++; $display("FAIL drop_quiet: got stall=%b we=%b addr=%h wdata=%h crd=%h expected 0",
                            d3_cpu_stall, d3_mem_we, d3_mem_addr, d3_mem_wdata, d3_cpu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_back_to_back();
        test_both();
        test_reset_midaccess();
        test_dma_drop();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL sb_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
